// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EXE stage: shift-add multiply and restoring divide.
// Define MDU_FAST_MULT_EN to replace the iterative multiply with a single-cycle array multiplier.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;    // multiply: {partial, multiplier}; divide: {rem, quot}
    logic [WIDTH-1:0]     r_opnd;   // multiplicand or divisor magnitude
    logic [1:0]           r_op;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH-1:0]     w_trial;
    logic                 w_borrow;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_fix_result;
    logic                 w_last_iter;
`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0]   w_fast_prod;
`endif

    assign w_mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign w_mag_b = (op[0] && b[WIDTH-1]) ? -b : b;

`ifdef MDU_FAST_MULT_EN
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

    // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: the shifted remainder is one bit wider than the divisor, so compare at WIDTH+1.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_borrow   = (w_rem_sh < {1'b0, r_opnd});
    assign w_trial    = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_next = w_borrow ? {r_acc[2*WIDTH-2:0], 1'b0}
                                 : {w_trial, r_acc[WIDTH-2:0], 1'b1};

    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_quot      = r_acc[WIDTH-1:0];
    assign w_rem       = r_acc[2*WIDTH-1:WIDTH];

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_fix_result = r_acc;
        if (r_op[1]) begin
            if (r_opnd != '0) begin
                w_fix_result[WIDTH-1:0]       = (r_op[0] && r_neg_q) ? -w_quot : w_quot;
                w_fix_result[2*WIDTH-1:WIDTH] = (r_op[0] && r_neg_r) ? -w_rem  : w_rem;
            end
        end else if (r_op[0] && r_neg_q) begin
            w_fix_result = -r_acc;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (flush && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start && !flush) begin
                        r_op    <= op;
                        r_neg_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= op[0] & a[WIDTH-1];
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (op[1]) begin
                            r_opnd  <= w_mag_b;
                            r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                            r_state <= S_CALC;
                        end else begin
`ifdef MDU_FAST_MULT_EN
                            r_opnd  <= w_mag_a;
                            r_acc   <= w_fast_prod;
                            r_state <= S_FIX;
`else
                            r_opnd  <= w_mag_a;
                            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                            r_state <= S_CALC;
`endif
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_iter) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_result[2*WIDTH-1:WIDTH];
                    r_lo    <= w_fix_result[WIDTH-1:0];
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EXE stage, directly downstream of the ID control decoder.
- Consumes the decoder's `start` pulse and `ALU2Op` encoding, with rs/rt operand values.
- Produces a 64-bit HI/LO result and busy/done status for the HI/LO register file and hazard logic.
- Multi-cycle; the pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin operation, sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  WIDTH  rs value: multiplicand or dividend
- b  in  WIDTH  rt value: multiplier or divisor
- flush  in  1  cancel the in-flight operation (exception/eret)
- busy  out  1  operation in progress; stall request
- done  out  1  one-cycle pulse, result valid
- hi  out  WIDTH  product[63:32] or remainder
- lo  out  WIDTH  product[31:0] or quotient

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - The counter and internal operand registers clear.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC when start=1 and flush=0.
  - CALC -> FIX after exactly WIDTH iterations; the counter runs 0..WIDTH-1.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
- Latching on start:
  - Latch the operand magnitudes: for signed ops (op[0]=1), take the two's-complement absolute value of a and b.
  - Latch the sign flags: neg_q = a[MSB]^b[MSB]; neg_r = a[MSB]. Both flags are 0 for unsigned ops.
  - Latch op.
- Multiply (CALC, one step per cycle): shift-add. If the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator, then shift right.
- Divide (CALC, one step per cycle): restoring.
  - Shift {rem, quot} left by one.
  - Trial-subtract the divisor from rem.
  - If no borrow, commit the subtraction and set quot LSB = 1.
- FIX:
  - Multiply: negate the 64-bit product if neg_q.
  - Divide: negate the quotient if neg_q; negate the remainder if neg_r.
  - Register the result into hi/lo at the FIX->DONE edge.
- Timing (start sampled at edge T; cycle k = cycle after edge T+k-1):
  - busy=1 in cycles 1..33 (CALC + FIX).
  - done=1 in cycle 34 only; busy=0 in that cycle.
- hi/lo hold their value from DONE until the next operation completes. They never change mid-operation.
- start while busy (CALC/FIX/DONE) is ignored; no queuing.
- Divide by zero (b==0):
  - Natural restoring result, no trap: lo=all ones, hi=a.
  - The FIX sign correction is skipped for divide-by-zero.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural magnitude result after negation.
- flush:
  - In any non-IDLE state: next state is IDLE, busy=0 next cycle, no done pulse, hi/lo unchanged.
  - flush and start together in IDLE: flush wins, no operation starts.
- Reset mid-operation behaves as the reset case above, including hi=lo=0.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute the full product combinationally at the start edge (WIDTH x WIDTH multiplier).
  - The product is latched and the FSM goes IDLE -> FIX -> DONE.
  - busy=1 in cycle 1 only; done=1 in cycle 2.
  - Divide timing is unchanged.
- Undefined: multiplies use the iterative path with 34-cycle latency; no multiplier is inferred.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> cycle 34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1. With MDU_FAST_MULT_EN the same values appear in cycle 2.
- DIVU a=100, b=7 -> cycle 34: lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Complete MULTU 2*3 (hi=0, lo=6). Then start DIVU 9/2 and assert flush in cycle 10 -> busy=0 from cycle 11, no done pulse, hi/lo stay 0/6.
- Start DIVU 9/2, pulse start with MULTU in cycle 5 -> second start ignored; cycle 34: lo=4, hi=1. Start+flush together in IDLE -> busy stays 0.
- Assert rst=0 for one edge during CALC -> next cycle busy=0, done=0, hi=lo=0. A new start then completes normally.
